// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: fetch FSM states and shared constants for the IF front end
package if_fetch_unit_pkg;
   typedef enum logic [1:0] {FETCH, FULL, DROP} state_e;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'b0;
endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// fetch_buffer: one-entry {pc4, instr} holding register; clear wins over load
module fetch_buffer
   import if_fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] pc4_i,
   input  logic [31:0]       instr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] pc4_o,
   output logic [31:0]       instr_o
);
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic [31:0]       instr_q, instr_d;

   // Cleared entries also zero their payload so the outputs are a bubble straight from the flops
   always_comb begin
      valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : valid_q;
      pc4_d   = clear_i ? '0 : load_i ? pc4_i : pc4_q;
      instr_d = clear_i ? NOP_INSTR : load_i ? instr_i : instr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc4_q   <= '0;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing sequential/redirected fetches into a one-entry IF buffer
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              valid_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic [31:0]       instruction_out
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, stale_q, stale_d, pc4, target;
   logic              load, clear, pending;

   assign pc4       = pc_q + ADDR_W'(4);
   assign target    = branch_addr & ~ADDR_W'(3);
   assign imem_req  = rst_n && (state_q != FULL || !freeze);
   assign imem_addr = state_q == DROP ? stale_q : pc_q;
   assign pending   = imem_req && !imem_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stale_d = stale_q;
      load    = 1'b0;
      clear   = 1'b0;
      if (branch_taken) begin
         clear = 1'b1;
         pc_d  = target;
         // An unaccepted request cannot be withdrawn, so remember it and swallow its data later
         if (state_q != DROP) begin
            state_d = pending ? DROP : FETCH;
            stale_d = pending ? pc_q : stale_q;
         end else if (imem_ready) begin
            state_d = FETCH;
         end
      end else begin
         case (state_q)
            FETCH: begin
               load    = imem_ready;
               pc_d    = imem_ready ? pc4 : pc_q;
               state_d = imem_ready ? FULL : FETCH;
            end
            FULL: begin
               load    = !freeze && imem_ready;
               clear   = !freeze && !imem_ready;
               pc_d    = load ? pc4 : pc_q;
               state_d = clear ? FETCH : FULL;
            end
            default: state_d = imem_ready ? FETCH : DROP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         stale_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
      end
   end

   fetch_buffer #(.ADDR_W(ADDR_W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .clear_i (clear),
      .pc4_i   (pc4),
      .instr_i (imem_rdata),
      .valid_o (valid_out),
      .pc4_o   (pc_out),
      .instr_o (instruction_out)
   );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plan checks plus randomized scoreboard against a program-order stream model
module tb_if_fetch_unit;
   localparam logic [31:0] XK = 32'hA5A5_0000;

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, freeze, branch_taken, imem_ready;
   logic [31:0] branch_addr;
   logic        imem_req, valid_out;
   logic [31:0] imem_addr, imem_rdata, pc_out, instruction_out;
   logic        req1, valid1;
   logic [31:0] addr1, rdata1, pc1, instr1;

   int   checks = 0, failures = 0;
   int   consumed = 0, gap = 0, max_gap = 0;
   bit   mon_en = 1'b0;
   exp_t q[$];
   logic [31:0] nxt;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ XK;
   assign rdata1     = addr1 ^ XK;

   if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .valid_out(valid_out),
      .pc_out(pc_out), .instruction_out(instruction_out)
   );

   if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .freeze(1'b0), .branch_taken(1'b0),
      .branch_addr(32'h0), .imem_req(req1), .imem_addr(addr1),
      .imem_ready(1'b1), .imem_rdata(rdata1), .valid_out(valid1),
      .pc_out(pc1), .instruction_out(instr1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected stream: from the current fetch target, addresses go up by 4; a branch restarts it
   task automatic top_up();
      while (q.size() < 4) begin
         q.push_back('{nxt + 32'd4, nxt ^ XK});
         nxt = nxt + 32'd4;
      end
   endtask

   initial begin : monitor
      bit          pend = 1'b0;
      logic [31:0] pend_addr = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (pend) begin
               chk("req_hold", {31'b0, imem_req}, 32'd1);
               chk("addr_hold", imem_addr, pend_addr);
            end
            pend      = imem_req && !imem_ready;
            pend_addr = imem_addr;
            if (!valid_out) begin
               chk("bubble_pc", pc_out, 32'd0);
               chk("bubble_instr", instruction_out, 32'd0);
            end
            if (valid_out && !freeze && !branch_taken) begin
               chk("exp_queue_nonempty", {31'b0, q.size() != 0}, 32'd1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("stream_pc", pc_out, e.pc4);
                  chk("stream_instr", instruction_out, e.instr);
               end
               consumed++;
               gap = 0;
            end else if (branch_taken) begin
               gap = 0;
            end else begin
               gap++;
               if (gap > max_gap) max_gap = gap;
            end
         end else begin
            pend = 1'b0;
         end
      end
   end

   initial begin
      rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_instr", instruction_out, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      chk("wrap_first_addr", addr1, 32'hFFFF_FFFC);
      @(negedge clk); #1;
      chk("seq_addr4", imem_addr, 32'd4);
      chk("seq_valid", {31'b0, valid_out}, 32'd1);
      chk("seq_pc4", pc_out, 32'd4);
      chk("seq_instr0", instruction_out, 32'd0 ^ XK);
      chk("wrap_pc_out", pc1, 32'd0);
      chk("wrap_second_addr", addr1, 32'd0);
      @(negedge clk); #1;
      chk("seq_addr8", imem_addr, 32'd8);
      chk("seq_pc8", pc_out, 32'd8);
      freeze = 1'b1;
      #1;
      chk("freeze_req", {31'b0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("frozen_pc", pc_out, 32'd8);
         chk("frozen_valid", {31'b0, valid_out}, 32'd1);
         chk("frozen_req", {31'b0, imem_req}, 32'd0);
      end
      freeze = 1'b0;
      @(negedge clk); #1;
      chk("unfreeze_pc", pc_out, 32'd12);
      chk("unfreeze_instr", instruction_out, 32'd8 ^ XK);
      @(negedge clk); #1;
      chk("pre_wait_addr", imem_addr, 32'h10);
      imem_ready = 1'b0;
      @(negedge clk); #1;
      chk("wait1_addr", imem_addr, 32'h10);
      chk("wait1_valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk); #1;
      chk("wait2_addr", imem_addr, 32'h10);
      branch_taken = 1'b1; branch_addr = 32'h40;
      @(negedge clk); #1;
      branch_taken = 1'b0;
      chk("drop_addr", imem_addr, 32'h10);
      chk("drop_req", {31'b0, imem_req}, 32'd1);
      chk("drop_valid", {31'b0, valid_out}, 32'd0);
      imem_ready = 1'b1;
      @(negedge clk); #1;
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk); #1;
      chk("redir_pc", pc_out, 32'h44);
      chk("redir_instr", instruction_out, 32'h40 ^ XK);
      freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h103; imem_ready = 1'b0;
      @(negedge clk); #1;
      freeze = 1'b0; branch_taken = 1'b0;
      chk("bf_valid", {31'b0, valid_out}, 32'd0);
      chk("bf_pc", pc_out, 32'd0);
      chk("bf_instr", instruction_out, 32'd0);
      chk("bf_addr", imem_addr, 32'h100);
      branch_taken = 1'b1; branch_addr = 32'h200;
      @(negedge clk); #1;
      branch_taken = 1'b0;
      chk("drop2_addr", imem_addr, 32'h100);
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'b0, imem_req}, 32'd0);
      chk("midrst_valid", {31'b0, valid_out}, 32'd0);
      chk("midrst_pc", pc_out, 32'd0);
      imem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("restart_addr", imem_addr, 32'd0);
      chk("restart_req", {31'b0, imem_req}, 32'd1);
      @(negedge clk); #1;
      chk("restart_pc", pc_out, 32'd4);

      rst_n = 1'b0;
      q.delete();
      nxt = 32'd0;
      top_up();
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         freeze       = ($urandom % 4) == 0;
         imem_ready   = c < 1500 ? ($urandom % 3) == 0 : ($urandom % 8) != 0;
         branch_taken = ($urandom % 16) == 0;
         branch_addr  = ($urandom % 4) == 0 ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_3FFF);
         if (branch_taken) begin
            q.delete();
            nxt = branch_addr & ~32'd3;
         end
         top_up();
      end
      @(negedge clk);
      branch_taken = 1'b0;
      mon_en = 1'b0;
      #5;
      chk("progress_min", {31'b0, consumed >= 200}, 32'd1);
      chk("stall_bound", {31'b0, max_gap <= 100}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
